// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the program counter, addresses a combinational instruction memory and
// issues one instruction per cycle to decode over a valid/ready handshake.
// Handles decode back-pressure, redirects, and halting on an all-zero word.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   IM_ADDRESS        word address to instruction memory (the PC register)
//   IM_INSTRUCTION    word returned combinationally for IM_ADDRESS
//   IF_VALID/IF_READY issue handshake to decode
//   IF_INSTRUCTION    issued instruction
//   IF_PC             address of the issued instruction
//   REDIRECT          one-cycle pulse: flush and restart at REDIRECT_PC
//   REDIRECT_PC       redirect target
//   RESUME            in HALT: skip the halting word, resume at PC+1
//   HALTED            fetch is halted
//   FETCH_COUNT       completed handshakes, saturating
module fetch_ctrl #(
   parameter int unsigned           PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
   parameter bit                    HALT_ON_ZERO = 1'b1
) (
   input  logic                CLK,
   input  logic                RST,
   output logic [PC_WIDTH-1:0] IM_ADDRESS,
   input  logic [31:0]         IM_INSTRUCTION,
   output logic                IF_VALID,
   input  logic                IF_READY,
   output logic [31:0]         IF_INSTRUCTION,
   output logic [PC_WIDTH-1:0] IF_PC,
   input  logic                REDIRECT,
   input  logic [PC_WIDTH-1:0] REDIRECT_PC,
   input  logic                RESUME,
   output logic                HALTED,
   output logic [15:0]         FETCH_COUNT
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                valid_q, valid_d;
   logic [31:0]         instr_q, instr_d;
   logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
   logic [15:0]         count_q, count_d;

   logic fire;
   logic out_free;
   logic halt_word;

   assign fire      = valid_q && IF_READY;
   assign out_free  = !valid_q || IF_READY;
   assign halt_word = HALT_ON_ZERO && (IM_INSTRUCTION == 32'h0);

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StRun;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= 32'h0;
         if_pc_q <= '0;
         count_q <= 16'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         if_pc_q <= if_pc_d;
         count_q <= count_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      if_pc_d = if_pc_q;

      if (REDIRECT) begin
         // Word at the old PC is dropped; a same-cycle fire still counts below.
         pc_d    = REDIRECT_PC;
         valid_d = 1'b0;
         state_d = StRun;
      end else begin
         unique case (state_q)
            StRun: begin
               if (out_free) begin
                  if (halt_word) begin
                     // PC stays on the halting word so RESUME can step past it.
                     state_d = StHalt;
                     valid_d = 1'b0;
                  end else begin
                     instr_d = IM_INSTRUCTION;
                     if_pc_d = pc_q;
                     valid_d = 1'b1;
                     pc_d    = pc_q + PC_WIDTH'(1);
                  end
               end
            end
            StHalt: begin
               if (fire) begin
                  valid_d = 1'b0;
               end
               if (RESUME) begin
                  pc_d    = pc_q + PC_WIDTH'(1);
                  state_d = StRun;
               end
            end
            default: state_d = StRun;
         endcase
      end

      count_d = count_q;
      if (fire && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   // Outputs
   always_comb begin
      IM_ADDRESS     = pc_q;
      IF_VALID       = valid_q;
      IF_INSTRUCTION = instr_q;
      IF_PC          = if_pc_q;
      HALTED         = (state_q == StHalt);
      FETCH_COUNT    = count_q;
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        resume;

   logic [31:0] im_address, im_instruction, if_instruction, if_pc;
   logic        if_valid, halted;
   logic [15:0] fetch_count;

   // Second instance: no halting, reset PC at all-ones to exercise wrap.
   logic [31:0] w_im_address, w_im_instruction, w_if_instruction, w_if_pc;
   logic        w_if_valid, w_halted;
   logic [15:0] w_fetch_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a < 32'd16) ? (32'hA500_0000 + a + 32'd1) : 32'h0;
   endfunction

   assign im_instruction   = mem(im_address);
   assign w_im_instruction = mem(w_im_address);

   fetch_ctrl #(.PC_WIDTH(32), .RESET_PC(32'h0), .HALT_ON_ZERO(1'b1)) u_dut (
      .CLK(clk), .RST(rst),
      .IM_ADDRESS(im_address), .IM_INSTRUCTION(im_instruction),
      .IF_VALID(if_valid), .IF_READY(if_ready),
      .IF_INSTRUCTION(if_instruction), .IF_PC(if_pc),
      .REDIRECT(redirect), .REDIRECT_PC(redirect_pc), .RESUME(resume),
      .HALTED(halted), .FETCH_COUNT(fetch_count)
   );

   fetch_ctrl #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFF), .HALT_ON_ZERO(1'b0)) u_wrap (
      .CLK(clk), .RST(rst),
      .IM_ADDRESS(w_im_address), .IM_INSTRUCTION(w_im_instruction),
      .IF_VALID(w_if_valid), .IF_READY(1'b1),
      .IF_INSTRUCTION(w_if_instruction), .IF_PC(w_if_pc),
      .REDIRECT(1'b0), .REDIRECT_PC(32'h0), .RESUME(1'b0),
      .HALTED(w_halted), .FETCH_COUNT(w_fetch_count)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; if_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; resume = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (im_address !== 32'h0) begin
         n_fail++; $display("FAIL reset_im_address got %h want 0", im_address); end
      n_tests++; if (if_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
      n_tests++; if (if_instruction !== 32'h0 || if_pc !== 32'h0) begin
         n_fail++; $display("FAIL reset_if_regs got %h/%h want 0/0", if_instruction, if_pc); end
      n_tests++; if (halted !== 1'b0 || fetch_count !== 16'h0) begin
         n_fail++; $display("FAIL reset_halt_count got %b/%0d want 0/0", halted, fetch_count); end
   endtask

   task automatic test_stream_halt();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step();
         n_tests++;
         if (if_valid !== 1'b1 || if_pc !== i || if_instruction !== mem(i)) begin
            n_fail++;
            $display("FAIL stream[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                     i, if_valid, if_pc, if_instruction, i, mem(i));
         end
      end
      n_tests++; if (im_address !== 32'd16) begin
         n_fail++; $display("FAIL stream_addr16 got %h want 10", im_address); end
      for (int k = 0; k < 3; k++) begin
         step();
         n_tests++;
         if (halted !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 16'd16 ||
             im_address !== 32'd16) begin
            n_fail++;
            $display("FAIL halt_hold[%0d] got h=%b v=%b cnt=%0d addr=%h want 1 0 16 10",
                     k, halted, if_valid, fetch_count, im_address);
         end
      end
   endtask

   task automatic test_backpressure_redirect();
      do_reset();
      step(); step(); step();
      n_tests++; if (if_pc !== 32'd2 || fetch_count !== 16'd2) begin
         n_fail++; $display("FAIL bp_setup got pc=%h cnt=%0d want 2 2", if_pc, fetch_count); end
      if_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_tests++;
         if (if_valid !== 1'b1 || if_pc !== 32'd2 || if_instruction !== mem(2) ||
             im_address !== 32'd3 || fetch_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_hold[%0d] got v=%b pc=%h ins=%h addr=%h cnt=%0d want 1 2 %h 3 2",
                     k, if_valid, if_pc, if_instruction, im_address, fetch_count, mem(2));
         end
      end
      if_ready = 1'b1;
      step();
      n_tests++; if (if_pc !== 32'd3 || if_instruction !== mem(3) || fetch_count !== 16'd3) begin
         n_fail++; $display("FAIL bp_release got pc=%h cnt=%0d want 3 3", if_pc, fetch_count); end
      step();
      n_tests++; if (if_pc !== 32'd4 || if_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_next got pc=%h v=%b want 4 1", if_pc, if_valid); end
      redirect = 1'b1; redirect_pc = 32'd9;
      step();
      redirect = 1'b0;
      n_tests++; if (if_valid !== 1'b0 || im_address !== 32'd9 || fetch_count !== 16'd5) begin
         n_fail++; $display("FAIL redir_flush got v=%b addr=%h cnt=%0d want 0 9 5",
                            if_valid, im_address, fetch_count); end
      step();
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'd9 || if_instruction !== mem(9)) begin
         n_fail++; $display("FAIL redir_target got v=%b pc=%h ins=%h want 1 9 %h",
                            if_valid, if_pc, if_instruction, mem(9)); end
      step();
      n_tests++; if (if_pc !== 32'd10 || fetch_count !== 16'd6) begin
         n_fail++; $display("FAIL redir_next got pc=%h cnt=%0d want a 6", if_pc, fetch_count); end
   endtask

   task automatic test_halt_resume();
      do_reset();
      for (int k = 0; k < 17; k++) step();
      n_tests++; if (halted !== 1'b1 || im_address !== 32'd16) begin
         n_fail++; $display("FAIL hr_halted got h=%b addr=%h want 1 10", halted, im_address); end
      resume = 1'b1;
      step();
      resume = 1'b0;
      n_tests++; if (halted !== 1'b0 || im_address !== 32'd17 || if_valid !== 1'b0) begin
         n_fail++; $display("FAIL hr_resume got h=%b addr=%h v=%b want 0 11 0",
                            halted, im_address, if_valid); end
      step();
      n_tests++; if (halted !== 1'b1 || im_address !== 32'd17 || if_valid !== 1'b0) begin
         n_fail++; $display("FAIL hr_rehalt got h=%b addr=%h v=%b want 1 11 0",
                            halted, im_address, if_valid); end
      redirect = 1'b1; redirect_pc = 32'd0;
      step();
      redirect = 1'b0;
      n_tests++; if (halted !== 1'b0 || im_address !== 32'd0 || if_valid !== 1'b0) begin
         n_fail++; $display("FAIL hr_redirect got h=%b addr=%h v=%b want 0 0 0",
                            halted, im_address, if_valid); end
      step();
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'd0 || fetch_count !== 16'd16) begin
         n_fail++; $display("FAIL hr_refetch got v=%b pc=%h cnt=%0d want 1 0 16",
                            if_valid, if_pc, fetch_count); end
   endtask

   task automatic test_wrap();
      do_reset();
      n_tests++; if (w_im_address !== 32'hFFFF_FFFF || w_if_valid !== 1'b0) begin
         n_fail++; $display("FAIL wrap_reset got addr=%h v=%b want ffffffff 0",
                            w_im_address, w_if_valid); end
      step();
      n_tests++;
      if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFF || w_if_instruction !== 32'h0 ||
          w_halted !== 1'b0) begin
         n_fail++; $display("FAIL wrap_zero_issue got v=%b pc=%h ins=%h h=%b want 1 ffffffff 0 0",
                            w_if_valid, w_if_pc, w_if_instruction, w_halted);
      end
      step();
      n_tests++; if (w_if_pc !== 32'h0 || w_if_instruction !== mem(0) || w_if_valid !== 1'b1) begin
         n_fail++; $display("FAIL wrap_to_zero got pc=%h ins=%h v=%b want 0 %h 1",
                            w_if_pc, w_if_instruction, w_if_valid, mem(0)); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 6; k++) step();
      if_ready = 1'b0;
      step();
      n_tests++; if (if_valid !== 1'b1 || fetch_count !== 16'd5 || if_pc !== 32'd5) begin
         n_fail++; $display("FAIL rm_setup got v=%b cnt=%0d pc=%h want 1 5 5",
                            if_valid, fetch_count, if_pc); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if (if_valid !== 1'b0 || if_pc !== 32'h0 || fetch_count !== 16'h0 ||
          im_address !== 32'h0 || halted !== 1'b0 || if_instruction !== 32'h0) begin
         n_fail++; $display("FAIL rm_reset got v=%b pc=%h cnt=%0d addr=%h h=%b ins=%h want 0s",
                            if_valid, if_pc, fetch_count, im_address, halted, if_instruction);
      end
      if_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stream_halt();
      test_backpressure_redirect();
      test_halt_resume();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the pipelined core. Owns the program counter, drives the word address of the combinational instruction memory, and presents one fetched instruction per cycle to decode through a valid/ready handshake. Handles decode back-pressure, branch/jump redirects, and halting on the all-zero word that the instruction memory returns for unpopulated addresses.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC, memory address and IF_PC.
- RESET_PC, 0, PC value loaded on reset.
- HALT_ON_ZERO, 1, when 1 a fetched word equal to 32'h0 halts fetch instead of being issued.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset, synchronous and active-high.
- IM_ADDRESS  out  PC_WIDTH  word address to instruction memory; equals PC register (combinational from register, no logic).
- IM_INSTRUCTION  in  32  instruction word returned combinationally for IM_ADDRESS.
- IF_VALID  out  1  IF_INSTRUCTION/IF_PC hold an issued instruction.
- IF_READY  in  1  decode accepts this cycle; low = stall.
- IF_INSTRUCTION  out  32  issued instruction.
- IF_PC  out  PC_WIDTH  address the issued instruction came from.
- REDIRECT  in  1  one-cycle pulse: flush and restart fetch at REDIRECT_PC.
- REDIRECT_PC  in  PC_WIDTH  redirect target (word address).
- RESUME  in  1  in HALT: skip halting word and resume fetch at PC+1.
- HALTED  out  1  fetch is in HALT state.
- FETCH_COUNT  out  16  count of completed IF handshakes.

## Operation
- States: RUN, HALT. HALTED = (state == HALT).
- Handshake completes (fire) when IF_VALID && IF_READY.
- Output stage is free when !IF_VALID || IF_READY.
- Priority per cycle: RST > REDIRECT > fetch/hold > RESUME.
- REDIRECT (any state): PC <= REDIRECT_PC; IF_VALID <= 0; state <= RUN. Word at old PC is discarded. A fire in the same cycle still counts.
- RUN, output free, no REDIRECT (fetch):
  - IM_INSTRUCTION == 0 and HALT_ON_ZERO: state <= HALT; IF_VALID <= 0; PC unchanged (points at halting word).
  - otherwise: IF_INSTRUCTION <= IM_INSTRUCTION; IF_PC <= PC; IF_VALID <= 1; PC <= PC + 1.
- RUN, IF_VALID && !IF_READY: all registers hold.
- HALT: no fetch. IF_VALID cleared when pending instruction fires (HALT is only entered with output free, so IF_VALID is 0). RESUME: PC <= PC + 1; state <= RUN. RESUME in RUN ignored.
- PC arithmetic modulo 2^PC_WIDTH; PC of all-ones increments to 0.
- FETCH_COUNT increments on each fire, saturates at 16'hFFFF.

## Timing
- Reset values: PC = RESET_PC (IM_ADDRESS = RESET_PC), IF_VALID = 0, IF_INSTRUCTION = 0, IF_PC = 0, HALTED = 0, FETCH_COUNT = 0, state RUN.
- Latency: word at IM_ADDRESS in cycle N appears on IF_INSTRUCTION with IF_VALID=1 in cycle N+1.
- Throughput: one instruction per cycle with IF_READY held high.
- Redirect penalty: REDIRECT in cycle N -> IF_VALID=0 in N+1, IM_ADDRESS=REDIRECT_PC in N+1, target issued in N+2.
- IF_INSTRUCTION/IF_PC are stable while IF_VALID && !IF_READY.
- HALT entry: HALTED rises the cycle after the zero word is sampled.
- RESUME in cycle N -> IM_ADDRESS = halt PC + 1 in N+1, issued N+2.
- RST asserted mid-stall or mid-HALT overrides everything; reset values next cycle.

## Test plan
- Memory holds nonzero words at 0..15, zero at 16+. Reset, IF_READY=1: IF_PC = 0,1,…,15 on consecutive cycles starting 1 cycle after reset release. HALTED=1 the cycle after IM_ADDRESS=16. IF_VALID=0 afterwards, FETCH_COUNT=16, IM_ADDRESS stays 16.
- Back-pressure: IF_READY=0 while IF_PC=2 for 3 cycles -> IF_PC=2, IF_INSTRUCTION=mem[2], IM_ADDRESS=3 held; FETCH_COUNT unchanged. Release -> IF_PC=3 next cycle, no skipped or duplicated PC.
- Redirect: REDIRECT=1, REDIRECT_PC=9 while IF_PC=4 and IF_READY=1 -> next cycle IF_VALID=0, IM_ADDRESS=9. Following cycle IF_PC=9. FETCH_COUNT includes PC 4 fire.
- HALT/RESUME: halted at 16, pulse RESUME -> IM_ADDRESS=17, re-halts (zero). REDIRECT_PC=0 in HALT -> HALTED=0 next cycle, IF_PC=0 the cycle after.
- Wrap: HALT_ON_ZERO=0, RESET_PC=32'hFFFF_FFFF -> IF_PC=32'hFFFF_FFFF then 0. Zero words issued with IF_VALID=1.
- Reset mid-operation: RST during stall with IF_VALID=1, FETCH_COUNT=5 -> next cycle IF_VALID=0, IF_PC=0, FETCH_COUNT=0, IM_ADDRESS=RESET_PC, HALTED=0.
